button_cmd_source: RTL and testbench
====================================

# button_cmd_source

Front-end command producer for the board-game datapath. It conditions the seven raw push-buttons: {blue_reset, red_reset, decision, up, down, left, right}. Each button is synchronized, debounced and edge-detected, and auto-repeats on held directions. The block emits one encoded 3-bit command per accepted event over a valid/ready handshake. It feeds the state-transition logic, replacing the level-sensitive 8-to-3 button encoding with a one-event-per-press command stream.

## Interface
- DB_CYCLES, 16, consecutive cycles a synchronized input must differ from its debounced level before the level flips (≥1)
- REPEAT_DELAY, 64, cycles from a direction press event to its first auto-repeat (≥2)
- REPEAT_PERIOD, 16, cycles between subsequent auto-repeats (≥1)
- clk  input  1  single clock; all state on rising edge
- reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high
- btn_raw  input  7  asynchronous buttons, bit6 blue_reset, bit5 red_reset, bit4 decision, bit3 up, bit2 down, bit1 left, bit0 right; 1 = pressed
- cmd  output  3  command code: 0 none, 1 right, 2 left, 3 down, 4 up, 5 decision, 6 red_reset, 7 blue_reset (bit index + 1)
- cmd_valid  output  1  cmd holds a pending command
- cmd_ready  input  1  consumer accepts cmd when cmd_valid && cmd_ready at a rising edge
- overflow  output  1  one-cycle pulse: an event was dropped or a pending command was overwritten

## Operation
- Synchronizer: two flops per bit. Output s[i].
- Debounce, per bit: counter db_cnt[i] and level stable[i].
  - If s[i]==stable[i], db_cnt clears.
  - Otherwise db_cnt increments. The edge on which it would reach DB_CYCLES instead toggles stable[i] and clears db_cnt.
- Press event: stable[i] toggling 0→1. A release toggle (1→0) produces no event.
- Arbitration: among simultaneous press events, the highest index wins. Each losing event pulses overflow.
- Auto-repeat, directions (bits 0-3) only:
  - One repeat tracker: rep_btn (index) and rep_cnt.
  - A direction press event loads rep_btn and clears rep_cnt.
  - rep_cnt counts while stable[rep_btn]==1.
  - A repeat event is generated at REPEAT_DELAY, then every REPEAT_PERIOD.
  - Release of rep_btn cancels tracking. A press event on any other button (including decision/reset) also cancels it.
  - Repeat events arbitrate below all same-cycle press events.
- Output register (cmd, cmd_valid):
  - Empty, or accepted this cycle (valid && ready), plus a winning event: load cmd, valid=1.
  - Accepted with no event: valid=0, cmd=0.
  - Pending, not accepted, event of code 1-5: event dropped, overflow=1, cmd unchanged.
  - Pending, not accepted, event of code 6/7: cmd overwritten with the reset code, overflow=1.
- cmd is 0 whenever cmd_valid=0.
- Reset values: sync flops, stable, db_cnt, rep tracker, cmd=0, cmd_valid=0, overflow=0.
- A button held through reset is seen as a fresh press after reset.

## Timing
- Press latency: count the first edge that samples the new raw level as edge 1. stable flips and cmd_valid rises at edge DB_CYCLES+2, provided the output register can load.
- Bounce rejection: any raw glitch shorter than DB_CYCLES cycles (after synchronization) produces no event.
- Repeat timing: the first repeat loads the output on the edge where rep_cnt reaches REPEAT_DELAY after the press event. Later repeats follow every REPEAT_PERIOD edges.
- Handshake:
  - cmd/cmd_valid are stable while valid && !ready.
  - Back-to-back acceptance is possible: valid stays 1 when accept and event coincide.
- overflow is registered and high for exactly one cycle per offending edge.
- Reset asserted mid-operation clears everything on that edge. A pending command is lost without overflow.

## Test plan
- Bounce: with cmd_ready=1, toggle btn_raw[3] every 3 cycles for 30 cycles, then hold 1 → exactly one cmd=4 valid pulse, arriving 18 edges after the final rising level. No overflow.
- Simultaneous press: raise bits 4 and 3 on the same cycle, with ready=1 → single cmd=5. overflow pulses once on the same edge.
- Backpressure: with ready=0, press right → cmd=1 held. Then press left → overflow pulse, cmd stays 1. Then press blue_reset → cmd=7, overflow pulse. Raise ready → one accept, then valid=0, cmd=0.
- Auto-repeat: with ready=1, hold right for 100 cycles after its first valid → cmd=1 accepted at offsets 0, 64, 80, 96. Releasing right → no further events. Pressing decision while up is held → cmd=5, and repeats of up stop.
- Reset mid-operation: cmd_valid=1 and rep tracking active, assert reset for 1 cycle → all outputs 0 on the next edge. A button still held yields a fresh event DB_CYCLES+2 edges after reset deasserts.
- Release path: press and release down, each level stable for 40 cycles → exactly one cmd=3. A release-only glitch produces nothing.

Source files
------------

// File: rtl/button_cmd_source.sv
// button_cmd_source
//
// Turns the seven raw board-game push-buttons into a stream of encoded
// commands, one command per accepted press. Every button goes through a
// two-flop synchronizer, a per-bit debounce counter and a rising-edge
// detector. A held direction button also auto-repeats. The consumer takes
// commands over a valid/ready handshake.
//
// Ports
//   clk        single clock, all state updates on the rising edge
//   reset      synchronous, active-high
//   btn_raw    asynchronous buttons, 1 = pressed
//              [6] blue_reset [5] red_reset [4] decision [3] up
//              [2] down [1] left [0] right
//   cmd        command code = button index + 1, 0 when nothing is pending
//   cmd_valid  cmd holds a pending command
//   cmd_ready  consumer takes cmd when cmd_valid && cmd_ready on an edge
//   overflow   one-cycle pulse: an event was dropped, or a pending command
//              was overwritten by a reset command

module button_cmd_source #(
    parameter int DB_CYCLES     = 16,
    parameter int REPEAT_DELAY  = 64,
    parameter int REPEAT_PERIOD = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] btn_raw,
    output logic [2:0] cmd,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic       overflow
);

    localparam int DB_W    = $clog2(DB_CYCLES + 1);
    localparam int REP_MAX = REPEAT_DELAY + REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DB_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_FIRST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_NEXT   = REP_W'(REP_MAX - 1);
    localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REPEAT_DELAY);

    typedef enum logic {
        REP_IDLE,
        REP_TRACK
    } rep_state_t;

    logic [6:0]      sync_1;
    logic [6:0]      sync_s;
    logic [6:0]      stable;
    logic [DB_W-1:0] db_cnt [7];

    logic [6:0] toggle;
    logic [6:0] press;
    logic [6:0] release_evt;
    logic       press_any;
    logic [2:0] press_idx;
    logic       multi_press;

    rep_state_t      rep_state;
    rep_state_t      rep_state_next;
    logic [1:0]      rep_btn;
    logic [1:0]      rep_btn_next;
    logic [REP_W-1:0] rep_cnt;
    logic [REP_W-1:0] rep_cnt_next;
    logic            rep_fire;

    logic       evt_valid;
    logic [2:0] evt_code;
    logic       evt_lost;
    logic       can_load;
    logic [2:0] cmd_next;
    logic       cmd_valid_next;
    logic       overflow_next;

    // Two-flop synchronizer. Clearing it on reset is what makes a button
    // held through reset look like a fresh press afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1 <= '0;
            sync_s <= '0;
        end else begin
            sync_1 <= btn_raw;
            sync_s <= sync_1;
        end
    end

    // A debounced level flips on the edge where its counter would reach
    // DB_CYCLES. Decoding that edge combinationally lets the press event
    // and the output load happen on the same edge as the flip.
    always_comb begin
        toggle = '0;
        for (int i = 0; i < 7; i++) begin
            toggle[i] = (sync_s[i] != stable[i]) && (db_cnt[i] == DB_LAST);
        end
        press       = toggle & ~stable;
        release_evt = toggle & stable;
    end

    // Debounce counters: cleared whenever the synchronized input agrees
    // with the debounced level, so any shorter glitch is forgotten.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable <= '0;
            for (int i = 0; i < 7; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 7; i++) begin
                if (sync_s[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (toggle[i]) begin
                    stable[i] <= ~stable[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Priority among same-edge presses: the highest index wins, because the
    // scan runs upward and later hits override earlier ones.
    always_comb begin
        press_idx = '0;
        for (int i = 0; i < 7; i++) begin
            if (press[i]) begin
                press_idx = 3'(i);
            end
        end
        press_any   = |press;
        multi_press = |(press & ~(7'd1 << press_idx));
    end

    // Auto-repeat tracker state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rep_state <= REP_IDLE;
            rep_btn   <= '0;
            rep_cnt   <= '0;
        end else begin
            rep_state <= rep_state_next;
            rep_btn   <= rep_btn_next;
            rep_cnt   <= rep_cnt_next;
        end
    end

    // Auto-repeat next state. The counter runs up to REPEAT_DELAY for the
    // first repeat, then cycles between REPEAT_DELAY and
    // REPEAT_DELAY + REPEAT_PERIOD for the later ones. Any press event
    // retargets or cancels tracking, and it takes priority over the
    // tracker's own update.
    always_comb begin
        rep_state_next = rep_state;
        rep_btn_next   = rep_btn;
        rep_cnt_next   = rep_cnt;
        rep_fire       = 1'b0;

        case (rep_state)
            REP_IDLE: begin
                rep_cnt_next = '0;
            end
            REP_TRACK: begin
                if (release_evt[rep_btn] || !stable[rep_btn]) begin
                    rep_state_next = REP_IDLE;
                    rep_cnt_next   = '0;
                end else if (rep_cnt == REP_FIRST || rep_cnt == REP_NEXT) begin
                    rep_fire     = 1'b1;
                    rep_cnt_next = REP_RELOAD;
                end else begin
                    rep_cnt_next = rep_cnt + REP_W'(1);
                end
            end
            default: begin
                rep_state_next = REP_IDLE;
                rep_cnt_next   = '0;
            end
        endcase

        if (press_any) begin
            rep_cnt_next = '0;
            if (press_idx < 3'd4) begin
                rep_state_next = REP_TRACK;
                rep_btn_next   = press_idx[1:0];
            end else begin
                rep_state_next = REP_IDLE;
            end
        end
    end

    // Event arbitration and the output register's next value. A repeat
    // ranks below any press on the same edge. A blocked register keeps
    // its command unless a reset code arrives, and reset codes overwrite.
    always_comb begin
        evt_valid = press_any | rep_fire;
        evt_code  = press_any ? (press_idx + 3'd1) : ({1'b0, rep_btn} + 3'd1);
        evt_lost  = multi_press | (press_any & rep_fire);
        can_load  = !cmd_valid || cmd_ready;

        cmd_next       = cmd;
        cmd_valid_next = cmd_valid;
        overflow_next  = evt_lost;

        if (can_load) begin
            if (evt_valid) begin
                cmd_next       = evt_code;
                cmd_valid_next = 1'b1;
            end else begin
                cmd_next       = '0;
                cmd_valid_next = 1'b0;
            end
        end else if (evt_valid) begin
            overflow_next = 1'b1;
            if (evt_code >= 3'd6) begin
                cmd_next = evt_code;
            end
        end
    end

    // Output register. Reset drops any pending command silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd       <= '0;
            cmd_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            cmd       <= cmd_next;
            cmd_valid <= cmd_valid_next;
            overflow  <= overflow_next;
        end
    end

endmodule

// File: tb/tb_button_cmd_source.sv
// tb_button_cmd_source
//
// Scoreboard bench for button_cmd_source. Each stimulus step that should
// produce a command pushes the expected code and, where it is known, the
// edge on which the command must appear. A negedge monitor pops an entry
// for every accepted command. Overflow pulses are counted separately.

module tb_button_cmd_source;

    localparam int DB = 16;

    localparam logic [6:0] B_RIGHT = 7'b0000001;
    localparam logic [6:0] B_LEFT  = 7'b0000010;
    localparam logic [6:0] B_DOWN  = 7'b0000100;
    localparam logic [6:0] B_UP    = 7'b0001000;
    localparam logic [6:0] B_DEC   = 7'b0010000;
    localparam logic [6:0] B_BLUE  = 7'b1000000;

    typedef struct packed {
        logic        timed;
        logic [2:0]  code;
        logic [31:0] cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] btn_raw;
    logic [2:0] cmd;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       overflow;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   ovf_count = 0;
    int   ovf_last_cyc = -1;
    int   last_drive = 0;
    int   base_ovf;
    int   t_ref;
    exp_t sb_q[$];
    exp_t mon_e;

    button_cmd_source #(
        .DB_CYCLES    (DB),
        .REPEAT_DELAY (64),
        .REPEAT_PERIOD(16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_raw  (btn_raw),
        .cmd      (cmd),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .overflow (overflow)
    );

    // Free-running clock and an edge counter used for latency expectations.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives a new button pattern just after an edge, remembers which edge
    // that was, then waits the requested number of edges.
    task automatic applyStimulus(input logic [6:0] value, input int cycles);
        btn_raw    = value;
        last_drive = cyc;
        stepCycles(cycles);
    endtask

    task automatic pushExpect(input logic [2:0] code, input logic timed,
                              input int at_cyc);
        exp_t e;
        e.timed = timed;
        e.code  = code;
        e.cyc   = 32'(at_cyc);
        sb_q.push_back(e);
    endtask

    // Monitor: looks half a cycle after each edge, so cyc names the edge
    // that loaded what is visible now.
    always @(negedge clk) begin
        if (!reset) begin
            if (overflow) begin
                ovf_count++;
                ovf_last_cyc = cyc;
            end
            if (cmd_valid && cmd_ready) begin
                if (sb_q.size() == 0) begin
                    checkOutput("unexpected_cmd_valid", 32'(cmd_valid), 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    checkOutput("cmd_code", 32'(cmd), 32'(mon_e.code));
                    if (mon_e.timed) begin
                        checkOutput("cmd_cycle", 32'(cyc), mon_e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        reset     = 1'b1;
        btn_raw   = '0;
        cmd_ready = 1'b1;
        stepCycles(3);
        checkOutput("reset_cmd", 32'(cmd), 0);
        checkOutput("reset_valid", 32'(cmd_valid), 0);
        checkOutput("reset_overflow", 32'(overflow), 0);
        reset = 1'b0;
        stepCycles(2);

        // Bounce on up, then a clean hold: one command, 18 edges later.
        base_ovf = ovf_count;
        for (int k = 0; k < 10; k++) begin
            applyStimulus((k % 2 == 0) ? B_UP : 7'b0, 3);
        end
        applyStimulus(B_UP, 0);
        pushExpect(3'd4, 1'b1, last_drive + DB + 2);
        stepCycles(40);
        applyStimulus('0, 60);
        checkOutput("bounce_pending", 32'(sb_q.size()), 0);
        checkOutput("bounce_overflow", 32'(ovf_count - base_ovf), 0);

        // Decision and up together: decision wins, one overflow pulse.
        base_ovf = ovf_count;
        applyStimulus(B_DEC | B_UP, 0);
        t_ref = last_drive + DB + 2;
        pushExpect(3'd5, 1'b1, t_ref);
        stepCycles(40);
        applyStimulus('0, 40);
        checkOutput("simul_pending", 32'(sb_q.size()), 0);
        checkOutput("simul_overflow", 32'(ovf_count - base_ovf), 1);
        checkOutput("simul_overflow_cycle", 32'(ovf_last_cyc), 32'(t_ref));

        // Backpressure: right held, left dropped, blue_reset overwrites.
        cmd_ready = 1'b0;
        base_ovf  = ovf_count;
        applyStimulus(B_RIGHT, 30);
        checkOutput("bp_hold_cmd", 32'(cmd), 1);
        checkOutput("bp_hold_valid", 32'(cmd_valid), 1);
        applyStimulus(B_RIGHT | B_LEFT, 30);
        checkOutput("bp_drop_cmd", 32'(cmd), 1);
        checkOutput("bp_drop_overflow", 32'(ovf_count - base_ovf), 1);
        applyStimulus(B_BLUE, 30);
        checkOutput("bp_blue_cmd", 32'(cmd), 7);
        checkOutput("bp_blue_valid", 32'(cmd_valid), 1);
        checkOutput("bp_blue_overflow", 32'(ovf_count - base_ovf), 2);
        pushExpect(3'd7, 1'b0, 0);
        cmd_ready = 1'b1;
        stepCycles(1);
        checkOutput("bp_after_valid", 32'(cmd_valid), 0);
        checkOutput("bp_after_cmd", 32'(cmd), 0);
        applyStimulus('0, 40);
        checkOutput("bp_pending", 32'(sb_q.size()), 0);
        checkOutput("bp_overflow_final", 32'(ovf_count - base_ovf), 2);

        // Auto-repeat of right at 0, 64, 80, 96, then release stops it.
        base_ovf = ovf_count;
        applyStimulus(B_RIGHT, 0);
        t_ref = last_drive + DB + 2;
        pushExpect(3'd1, 1'b1, t_ref);
        pushExpect(3'd1, 1'b1, t_ref + 64);
        pushExpect(3'd1, 1'b1, t_ref + 80);
        pushExpect(3'd1, 1'b1, t_ref + 96);
        stepCycles(DB + 2 + 90);
        applyStimulus('0, 60);
        checkOutput("repeat_pending", 32'(sb_q.size()), 0);

        // Decision pressed while up is held cancels the up repeat.
        applyStimulus(B_UP, 0);
        pushExpect(3'd4, 1'b1, last_drive + DB + 2);
        stepCycles(48);
        applyStimulus(B_UP | B_DEC, 0);
        pushExpect(3'd5, 1'b1, last_drive + DB + 2);
        stepCycles(100);
        applyStimulus('0, 40);
        checkOutput("cancel_pending", 32'(sb_q.size()), 0);
        checkOutput("repeat_overflow", 32'(ovf_count - base_ovf), 0);

        // Reset with a pending command and live tracking, button still held.
        cmd_ready = 1'b0;
        base_ovf  = ovf_count;
        applyStimulus(B_UP, 30);
        checkOutput("rst_pre_valid", 32'(cmd_valid), 1);
        reset = 1'b1;
        stepCycles(1);
        checkOutput("rst_cmd", 32'(cmd), 0);
        checkOutput("rst_valid", 32'(cmd_valid), 0);
        checkOutput("rst_overflow", 32'(overflow), 0);
        reset     = 1'b0;
        cmd_ready = 1'b1;
        pushExpect(3'd4, 1'b1, cyc + DB + 2);
        stepCycles(30);
        applyStimulus('0, 50);
        checkOutput("rst_pending", 32'(sb_q.size()), 0);
        checkOutput("rst_overflow_count", 32'(ovf_count - base_ovf), 0);

        // Press/release of down, then a short release glitch while held.
        base_ovf = ovf_count;
        applyStimulus(B_DOWN, 0);
        pushExpect(3'd3, 1'b1, last_drive + DB + 2);
        stepCycles(40);
        applyStimulus('0, 40);
        applyStimulus(B_DOWN, 0);
        pushExpect(3'd3, 1'b1, last_drive + DB + 2);
        stepCycles(30);
        applyStimulus('0, 5);
        applyStimulus(B_DOWN, 20);
        applyStimulus('0, 40);
        checkOutput("release_pending", 32'(sb_q.size()), 0);
        checkOutput("release_overflow", 32'(ovf_count - base_ovf), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
